pspin_tx_merge: RTL and testbench
=================================

// Module: pspin_tx_merge
//
// PURPOSE
// Packet-granular 2:1 AXI-Stream merge on the transmit side, the counterpart of the RX
// match/split stage. Merges host TX traffic from the NIC datapath with egress packets from
// PsPIN into a single stream toward the NIC TX/MAC. Packets are never interleaved: a grant
// is held from the first beat to tlast. Output is registered; per-source packet counters
// are exposed for CSR readout.
//
// PARAMETERS
// AXIS_IF_DATA_WIDTH     512                     tdata width
// AXIS_IF_KEEP_WIDTH     AXIS_IF_DATA_WIDTH/8    tkeep width
// AXIS_IF_TX_ID_WIDTH    1                       tid width
// AXIS_IF_TX_DEST_WIDTH  8                       tdest width
// AXIS_IF_TX_USER_WIDTH  17                      tuser width
//
// PORTS
// clk                  in   1      clock; all logic on the rising edge
// rstn                 in   1      synchronous, active-low reset
// s_axis_nic_tx_t*     in/out      host TX stream (tdata,tkeep,tvalid,tready(out),tlast,tid,tdest,tuser)
// s_axis_pspin_tx_t*   in/out      PsPIN egress stream, same signal set/widths
// m_axis_nic_tx_t*     out/in      merged stream toward MAC, same signal set (tready is input)
// merge_mode           in   2      0: round-robin, 1: PsPIN strict priority, 2: NIC strict priority, 3: as 0
// stat_nic_pkts        out  32     packets (tlast beats) accepted from s_axis_nic_tx
// stat_pspin_pkts      out  32     packets accepted from s_axis_pspin_tx
// busy                 out  1      high while FSM not IDLE
//
// BEHAVIOUR
// - Reset (rstn=0 at an edge): FSM->IDLE, out tvalid=0, out tdata/tkeep/tlast/tid/tdest/tuser=0,
//   both s_*_tready=0 during reset, rr_last=PSPIN (so NIC wins first RR tie), counters=0, busy=0.
//   Reset mid-packet drops any partial packet; no recovery beat is emitted.
// - Output register: load_en = !m_tvalid || m_tready. s_*_tready = load_en && granted(source).
//   A beat transfers on an input when its tvalid && tready; it appears on m_axis 1 cycle later.
//   m_tvalid clears when m_tready && no new beat loaded. Payload held stable while m_tvalid && !m_tready.
// - FSM states: IDLE, NIC, PSPIN.
//   IDLE: grant computed combinationally from tvalids and merge_mode:
//     mode 1: PsPIN if valid else NIC; mode 2: NIC if valid else PsPIN;
//     mode 0/3: both valid -> source != rr_last; one valid -> that one.
//   First beat may transfer in the IDLE cycle (zero-bubble). On first-beat transfer:
//     tlast=1 -> stay IDLE; tlast=0 -> go to NIC/PSPIN. rr_last updated to granted source.
//   NIC / PSPIN: only that source has tready; other input stalls. Transfer with tlast -> IDLE.
//   No grant/transfer when load_en=0; FSM holds.
// - merge_mode sampled only in IDLE; changes mid-packet take effect at next packet.
// - Input tvalid dropping mid-packet is legal: FSM waits, grant held indefinitely (no timeout).
// - Counters increment on input-side transfer of a tlast beat; 32-bit, wrap 0xFFFFFFFF->0.
//   Both may increment in separate cycles only (one source granted per cycle).
// - tid/tdest/tuser/tkeep pass per beat unmodified; no width conversion or packet checks.
// - busy = (state != IDLE).
//
// TESTING
// 1. Reset, then NIC sends 3-beat pkt, m_tready=1 -> beats on m_axis at cycles 1..3 after
//    first accept, tlast on 3rd, stat_nic_pkts=1, s_pspin tready=0 throughout.
// 2. mode 0, both sources continuously valid with 2-beat pkts -> output order NIC,PSPIN,NIC,PSPIN;
//    no beat of one packet between beats of another; zero idle cycles between packets.
// 3. mode 1, both valid -> four PsPIN pkts before any NIC pkt; switch to mode 2 mid-packet ->
//    current PsPIN pkt completes, next packet is NIC.
// 4. m_tready toggled 1,0,0,1 pseudo-randomly during 8-beat pkt -> output data matches input
//    exactly, held stable while stalled, no beat dropped/duplicated.
// 5. Assert rstn=0 for 1 cycle at beat 2 of 5-beat PsPIN pkt -> next cycle m_tvalid=0,
//    counters=0, busy=0; following fresh NIC pkt forwarded intact.
// 6. Preload-free wrap: send 2^32+1 single-beat NIC pkts (or force counter to 0xFFFFFFFF) ->
//    stat_nic_pkts wraps to 0 then 1.

Source files
------------

// File: rtl/pspin_tx_merge_if.sv
// AXI-Stream bundle used on both merge inputs and the merged output.
//
// Handshake: a beat moves on a rising edge where tvalid && tready are both
// high. The master holds tdata/tkeep/tlast/tid/tdest/tuser stable while
// tvalid is high and tready is low. tready may depend combinationally on tvalid.
interface pspin_tx_merge_if #(
   parameter int DATA_W = 512,
   parameter int KEEP_W = DATA_W / 8,
   parameter int ID_W   = 1,
   parameter int DEST_W = 8,
   parameter int USER_W = 17
);
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [ID_W-1:0]   tid;
   logic [DEST_W-1:0] tdest;
   logic [USER_W-1:0] tuser;

   modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/pspin_tx_merge.sv
// Packet-granular 2:1 AXI-Stream merge (host TX + PsPIN egress -> MAC).
// A grant is held from the first beat to tlast, so packets never interleave.
// The output beat is registered; per-source packet counters feed the CSRs.
module pspin_tx_merge #(
   parameter int AXIS_IF_DATA_WIDTH    = 512,
   parameter int AXIS_IF_KEEP_WIDTH    = AXIS_IF_DATA_WIDTH / 8,
   parameter int AXIS_IF_TX_ID_WIDTH   = 1,
   parameter int AXIS_IF_TX_DEST_WIDTH = 8,
   parameter int AXIS_IF_TX_USER_WIDTH = 17
) (
   input  logic                    clk,
   input  logic                    rstn,
   pspin_tx_merge_if.slave         s_axis_nic_tx,
   pspin_tx_merge_if.slave         s_axis_pspin_tx,
   pspin_tx_merge_if.master        m_axis_nic_tx,
   input  logic [1:0]              merge_mode,
   output logic [31:0]             stat_nic_pkts,
   output logic [31:0]             stat_pspin_pkts,
   output logic                    busy,
   output logic [1:0]              o_dbg_state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_NIC   = 2'd1;
   localparam logic [1:0] S_PSPIN = 2'd2;

   // rr_last encodes which source most recently won a packet
   localparam logic RR_NIC   = 1'b0;
   localparam logic RR_PSPIN = 1'b1;

   logic [1:0]                       r_state;
   logic                             r_rr_last;
   logic                             r_m_tvalid;
   logic [AXIS_IF_DATA_WIDTH-1:0]    r_m_tdata;
   logic [AXIS_IF_KEEP_WIDTH-1:0]    r_m_tkeep;
   logic                             r_m_tlast;
   logic [AXIS_IF_TX_ID_WIDTH-1:0]   r_m_tid;
   logic [AXIS_IF_TX_DEST_WIDTH-1:0] r_m_tdest;
   logic [AXIS_IF_TX_USER_WIDTH-1:0] r_m_tuser;
   logic [31:0]                      r_stat_nic;
   logic [31:0]                      r_stat_pspin;

   logic w_load_en;
   logic w_nic_v;
   logic w_pspin_v;
   logic w_grant_nic;
   logic w_grant_pspin;
   logic w_nic_rdy;
   logic w_pspin_rdy;
   logic w_xfer_nic;
   logic w_xfer_pspin;

   assign w_nic_v   = s_axis_nic_tx.tvalid;
   assign w_pspin_v = s_axis_pspin_tx.tvalid;

   // The output register can take a new beat when empty or draining this cycle
   assign w_load_en = !r_m_tvalid || m_axis_nic_tx.tready;

   // Grant: held by the owning source mid-packet, arbitrated by merge_mode in IDLE
   always_comb begin
      w_grant_nic   = 1'b0;
      w_grant_pspin = 1'b0;
      case (r_state)
         S_NIC:   w_grant_nic   = 1'b1;
         S_PSPIN: w_grant_pspin = 1'b1;
         default: begin
            case (merge_mode)
               2'd1: begin
                  w_grant_pspin = w_pspin_v;
                  w_grant_nic   = !w_pspin_v && w_nic_v;
               end
               2'd2: begin
                  w_grant_nic   = w_nic_v;
                  w_grant_pspin = !w_nic_v && w_pspin_v;
               end
               default: begin
                  if (w_nic_v && w_pspin_v) begin
                     w_grant_nic   = (r_rr_last == RR_PSPIN);
                     w_grant_pspin = (r_rr_last == RR_NIC);
                  end else begin
                     w_grant_nic   = w_nic_v;
                     w_grant_pspin = w_pspin_v;
                  end
               end
            endcase
         end
      endcase
   end

   assign w_nic_rdy    = rstn && w_load_en && w_grant_nic;
   assign w_pspin_rdy  = rstn && w_load_en && w_grant_pspin;
   assign w_xfer_nic   = w_nic_v && w_nic_rdy;
   assign w_xfer_pspin = w_pspin_v && w_pspin_rdy;

   assign s_axis_nic_tx.tready   = w_nic_rdy;
   assign s_axis_pspin_tx.tready = w_pspin_rdy;

   // Output register: load the granted beat, or drop tvalid once the sink takes it
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_m_tvalid <= 1'b0;
         r_m_tdata  <= '0;
         r_m_tkeep  <= '0;
         r_m_tlast  <= 1'b0;
         r_m_tid    <= '0;
         r_m_tdest  <= '0;
         r_m_tuser  <= '0;
      end else if (w_load_en) begin
         if (w_xfer_nic) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= s_axis_nic_tx.tdata;
            r_m_tkeep  <= s_axis_nic_tx.tkeep;
            r_m_tlast  <= s_axis_nic_tx.tlast;
            r_m_tid    <= s_axis_nic_tx.tid;
            r_m_tdest  <= s_axis_nic_tx.tdest;
            r_m_tuser  <= s_axis_nic_tx.tuser;
         end else if (w_xfer_pspin) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= s_axis_pspin_tx.tdata;
            r_m_tkeep  <= s_axis_pspin_tx.tkeep;
            r_m_tlast  <= s_axis_pspin_tx.tlast;
            r_m_tid    <= s_axis_pspin_tx.tid;
            r_m_tdest  <= s_axis_pspin_tx.tdest;
            r_m_tuser  <= s_axis_pspin_tx.tuser;
         end else begin
            r_m_tvalid <= 1'b0;
         end
      end
   end

   // Packet FSM: a single-beat packet never leaves IDLE; tlast releases the grant
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_rr_last <= RR_PSPIN;
      end else begin
         case (r_state)
            S_NIC: begin
               if (w_xfer_nic && s_axis_nic_tx.tlast) r_state <= S_IDLE;
            end
            S_PSPIN: begin
               if (w_xfer_pspin && s_axis_pspin_tx.tlast) r_state <= S_IDLE;
            end
            default: begin
               if (w_xfer_nic) begin
                  r_rr_last <= RR_NIC;
                  if (!s_axis_nic_tx.tlast) r_state <= S_NIC;
               end else if (w_xfer_pspin) begin
                  r_rr_last <= RR_PSPIN;
                  if (!s_axis_pspin_tx.tlast) r_state <= S_PSPIN;
               end
            end
         endcase
      end
   end

   // Packet counters: count tlast beats accepted on each input, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_stat_nic   <= '0;
         r_stat_pspin <= '0;
      end else begin
         if (w_xfer_nic && s_axis_nic_tx.tlast)     r_stat_nic   <= r_stat_nic + 32'd1;
         if (w_xfer_pspin && s_axis_pspin_tx.tlast) r_stat_pspin <= r_stat_pspin + 32'd1;
      end
   end

   assign m_axis_nic_tx.tvalid = r_m_tvalid;
   assign m_axis_nic_tx.tdata  = r_m_tdata;
   assign m_axis_nic_tx.tkeep  = r_m_tkeep;
   assign m_axis_nic_tx.tlast  = r_m_tlast;
   assign m_axis_nic_tx.tid    = r_m_tid;
   assign m_axis_nic_tx.tdest  = r_m_tdest;
   assign m_axis_nic_tx.tuser  = r_m_tuser;

   assign stat_nic_pkts   = r_stat_nic;
   assign stat_pspin_pkts = r_stat_pspin;
   assign busy            = (r_state != S_IDLE);
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_pspin_tx_merge.sv
// Directed bench for pspin_tx_merge: queue-fed source drivers, an output
// monitor logging beats, and per-test comparison against hand-built order.
module tb_pspin_tx_merge;

   logic        clk;
   logic        rstn;
   logic [1:0]  merge_mode;
   logic [31:0] stat_nic_pkts;
   logic [31:0] stat_pspin_pkts;
   logic        busy;
   logic [1:0]  dbg_state;

   pspin_tx_merge_if nic_if ();
   pspin_tx_merge_if ps_if ();
   pspin_tx_merge_if m_if ();

   pspin_tx_merge dut (
      .clk             (clk),
      .rstn            (rstn),
      .s_axis_nic_tx   (nic_if),
      .s_axis_pspin_tx (ps_if),
      .m_axis_nic_tx   (m_if),
      .merge_mode      (merge_mode),
      .stat_nic_pkts   (stat_nic_pkts),
      .stat_pspin_pkts (stat_pspin_pkts),
      .busy            (busy),
      .o_dbg_state     (dbg_state)
   );

   // clock / cycle count
   initial clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // beat word: data[31:0] tuser[48:32] tdest[56:49] tid[57] last[58] keep[90:59]
   logic [95:0] nic_q[$];
   logic [95:0] ps_q[$];
   logic [95:0] exp_q[$];
   logic [95:0] got_q[$];
   int          got_cyc[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [95:0] mk_word(input int src, input int tst, input int pkt,
                                           input int beat, input logic last);
      logic [31:0] d;
      logic [95:0] w;
      d = {src[7:0], tst[7:0], pkt[7:0], beat[7:0]};
      w = '0;
      w[31:0]  = d;
      w[48:32] = d[16:0] ^ 17'h1ABCD;
      w[56:49] = d[15:8] ^ 8'hC3;
      w[57]    = src[0];
      w[58]    = last;
      w[90:59] = ~d;
      return w;
   endfunction

   // src 0 = NIC, 1 = PsPIN; optionally also expected on the output
   task automatic add_pkt(input int src, input int tst, input int pkt, input int nb, input bit expd);
      for (int b = 0; b < nb; b++) begin
         if (src == 0) nic_q.push_back(mk_word(src, tst, pkt, b, b == nb - 1));
         else          ps_q.push_back(mk_word(src, tst, pkt, b, b == nb - 1));
         if (expd) exp_q.push_back(mk_word(src, tst, pkt, b, b == nb - 1));
      end
   endtask

   // NIC source driver
   int nic_acc = 0;
   int nic_first_cyc = 0;
   initial begin
      logic        fire;
      logic [95:0] w;
      nic_if.tvalid = 1'b0;
      nic_if.tdata  = '0;
      nic_if.tkeep  = '0;
      nic_if.tlast  = 1'b0;
      nic_if.tid    = '0;
      nic_if.tdest  = '0;
      nic_if.tuser  = '0;
      forever begin
         @(negedge clk);
         fire = nic_if.tvalid && nic_if.tready;
         if (fire && nic_acc == 0) nic_first_cyc = cyc;
         @(posedge clk);
         #1;
         if (fire && nic_q.size() > 0) void'(nic_q.pop_front());
         if (fire) nic_acc++;
         if (nic_q.size() > 0) begin
            w = nic_q[0];
            nic_if.tvalid      = 1'b1;
            nic_if.tdata       = '0;
            nic_if.tdata[31:0] = w[31:0];
            nic_if.tuser       = w[48:32];
            nic_if.tdest       = w[56:49];
            nic_if.tid         = w[57];
            nic_if.tlast       = w[58];
            nic_if.tkeep       = '0;
            nic_if.tkeep[31:0] = w[90:59];
         end else begin
            nic_if.tvalid = 1'b0;
         end
      end
   end

   // PsPIN source driver
   int ps_acc = 0;
   initial begin
      logic        fire;
      logic [95:0] w;
      ps_if.tvalid = 1'b0;
      ps_if.tdata  = '0;
      ps_if.tkeep  = '0;
      ps_if.tlast  = 1'b0;
      ps_if.tid    = '0;
      ps_if.tdest  = '0;
      ps_if.tuser  = '0;
      forever begin
         @(negedge clk);
         fire = ps_if.tvalid && ps_if.tready;
         @(posedge clk);
         #1;
         if (fire && ps_q.size() > 0) void'(ps_q.pop_front());
         if (fire) ps_acc++;
         if (ps_q.size() > 0) begin
            w = ps_q[0];
            ps_if.tvalid      = 1'b1;
            ps_if.tdata       = '0;
            ps_if.tdata[31:0] = w[31:0];
            ps_if.tuser       = w[48:32];
            ps_if.tdest       = w[56:49];
            ps_if.tid         = w[57];
            ps_if.tlast       = w[58];
            ps_if.tkeep       = '0;
            ps_if.tkeep[31:0] = w[90:59];
         end else begin
            ps_if.tvalid = 1'b0;
         end
      end
   end

   // sink ready: always 1, or a fixed stall pattern 1,0,0,1,0,1,1,0
   logic       rdy_pat_en = 1'b0;
   logic [7:0] rdy_pat    = 8'b0110_1001;
   int         rdy_idx    = 0;
   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_pat_en) begin
            m_if.tready = rdy_pat[rdy_idx % 8];
            rdy_idx++;
         end else begin
            m_if.tready = 1'b1;
         end
      end
   end

   // output monitor: log accepted beats, check payload held during stalls
   logic        prev_stall = 1'b0;
   logic [95:0] prev_word  = '0;
   logic        watch_ps   = 1'b0;
   logic        ps_rdy_seen = 1'b0;
   always @(negedge clk) begin
      logic [95:0] w;
      w = '0;
      w[31:0]  = m_if.tdata[31:0];
      w[48:32] = m_if.tuser;
      w[56:49] = m_if.tdest;
      w[57]    = m_if.tid;
      w[58]    = m_if.tlast;
      w[90:59] = m_if.tkeep[31:0];
      if (!rstn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", {95'b0, m_if.tvalid}, 96'd1);
            check("hold_data", w, prev_word);
         end
         if (m_if.tvalid && m_if.tready) begin
            got_q.push_back(w);
            got_cyc.push_back(cyc);
         end
         prev_stall = m_if.tvalid && !m_if.tready;
         prev_word  = w;
      end
      if (watch_ps && ps_if.tready) ps_rdy_seen = 1'b1;
   end

   task automatic clear_logs();
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int  n;
      bit  done;
      n    = 0;
      done = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
         done = (nic_q.size() == 0) && (ps_q.size() == 0) && !m_if.tvalid;
      end
      if (!done) check({tag, "_timeout"}, 96'd0, 96'd1);
   endtask

   task automatic compare_logs(input string tag);
      check({tag, "_nbeats"}, 96'(got_q.size()), 96'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic wait_acc(input string tag, input int which, input int target, input int budget);
      int n;
      n = 0;
      while (((which == 0) ? nic_acc : ps_acc) < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) check({tag, "_acc_timeout"}, 96'd0, 96'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rstn       = 1'b0;
      merge_mode = 2'd0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_m_tvalid", {95'b0, m_if.tvalid}, 96'd0);
      check("rst_m_tdata",  96'(m_if.tdata[31:0]), 96'd0);
      check("rst_m_tlast",  {95'b0, m_if.tlast}, 96'd0);
      check("rst_busy",     {95'b0, busy}, 96'd0);
      check("rst_stat_nic", 96'(stat_nic_pkts), 96'd0);
      check("rst_stat_ps",  96'(stat_pspin_pkts), 96'd0);
      check("rst_nic_rdy",  {95'b0, nic_if.tready}, 96'd0);
      check("rst_ps_rdy",   {95'b0, ps_if.tready}, 96'd0);
      rstn = 1'b1;

      // T1: single 3-beat NIC packet, 1-cycle latency, PsPIN never ready
      clear_logs();
      nic_acc     = 0;
      ps_rdy_seen = 1'b0;
      watch_ps    = 1'b1;
      add_pkt(0, 1, 0, 3, 1);
      wait_drain("t1", 50);
      watch_ps = 1'b0;
      compare_logs("t1");
      check("t1_ps_tready", {95'b0, ps_rdy_seen}, 96'd0);
      if (got_cyc.size() >= 3) begin
         check("t1_lat_first", 96'(got_cyc[0] - nic_first_cyc), 96'd1);
         check("t1_lat_last",  96'(got_cyc[2] - nic_first_cyc), 96'd3);
      end
      check("t1_stat_nic", 96'(stat_nic_pkts), 96'd1);
      check("t1_stat_ps",  96'(stat_pspin_pkts), 96'd0);

      // T2: round-robin from reset, NIC wins the first tie, no bubbles
      do_reset();
      clear_logs();
      merge_mode = 2'd0;
      add_pkt(0, 2, 0, 2, 0);
      add_pkt(0, 2, 1, 2, 0);
      add_pkt(1, 2, 0, 2, 0);
      add_pkt(1, 2, 1, 2, 0);
      exp_q.push_back(mk_word(0, 2, 0, 0, 0));
      exp_q.push_back(mk_word(0, 2, 0, 1, 1));
      exp_q.push_back(mk_word(1, 2, 0, 0, 0));
      exp_q.push_back(mk_word(1, 2, 0, 1, 1));
      exp_q.push_back(mk_word(0, 2, 1, 0, 0));
      exp_q.push_back(mk_word(0, 2, 1, 1, 1));
      exp_q.push_back(mk_word(1, 2, 1, 0, 0));
      exp_q.push_back(mk_word(1, 2, 1, 1, 1));
      wait_drain("t2", 60);
      compare_logs("t2");
      if (got_cyc.size() >= 8) check("t2_no_bubble", 96'(got_cyc[7] - got_cyc[0]), 96'd7);
      check("t2_stat_nic", 96'(stat_nic_pkts), 96'd2);
      check("t2_stat_ps",  96'(stat_pspin_pkts), 96'd2);

      // T3: PsPIN priority, then NIC priority taking effect after the current packet
      clear_logs();
      merge_mode = 2'd1;
      ps_acc     = 0;
      for (int p = 0; p < 6; p++) add_pkt(1, 3, p, 2, 0);
      add_pkt(0, 3, 0, 2, 0);
      add_pkt(0, 3, 1, 2, 0);
      for (int p = 0; p < 5; p++) begin
         exp_q.push_back(mk_word(1, 3, p, 0, 0));
         exp_q.push_back(mk_word(1, 3, p, 1, 1));
      end
      for (int p = 0; p < 2; p++) begin
         exp_q.push_back(mk_word(0, 3, p, 0, 0));
         exp_q.push_back(mk_word(0, 3, p, 1, 1));
      end
      exp_q.push_back(mk_word(1, 3, 5, 0, 0));
      exp_q.push_back(mk_word(1, 3, 5, 1, 1));
      wait_acc("t3", 1, 9, 60);
      merge_mode = 2'd2;
      check("t3_busy_mid", {95'b0, busy}, 96'd1);
      wait_drain("t3", 80);
      compare_logs("t3");
      merge_mode = 2'd0;

      // T4: 8-beat NIC packet through a stalling sink
      clear_logs();
      rdy_idx    = 0;
      rdy_pat_en = 1'b1;
      add_pkt(0, 4, 0, 8, 1);
      wait_drain("t4", 200);
      rdy_pat_en = 1'b0;
      compare_logs("t4");

      // T5: reset at beat 2 of a 5-beat PsPIN packet, then a clean NIC packet
      clear_logs();
      ps_acc = 0;
      add_pkt(1, 5, 0, 5, 0);
      wait_acc("t5", 1, 2, 50);
      check("t5_busy_before", {95'b0, busy}, 96'd1);
      rstn = 1'b0;
      ps_q.delete();
      @(negedge clk);
      check("t5_m_tvalid", {95'b0, m_if.tvalid}, 96'd0);
      check("t5_stat_nic", 96'(stat_nic_pkts), 96'd0);
      check("t5_stat_ps",  96'(stat_pspin_pkts), 96'd0);
      check("t5_busy",     {95'b0, busy}, 96'd0);
      rstn = 1'b1;
      clear_logs();
      add_pkt(0, 5, 1, 3, 1);
      wait_drain("t5", 50);
      compare_logs("t5");
      check("t5_stat_nic_after", 96'(stat_nic_pkts), 96'd1);
      check("t5_stat_ps_after",  96'(stat_pspin_pkts), 96'd0);

      // T6: counter wrap from 0xFFFFFFFF with single-beat packets
      clear_logs();
      force dut.r_stat_nic = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.r_stat_nic;
      @(negedge clk);
      add_pkt(0, 6, 0, 1, 1);
      wait_drain("t6a", 30);
      check("t6_wrap0", 96'(stat_nic_pkts), 96'd0);
      check("t6_busy",  {95'b0, busy}, 96'd0);
      add_pkt(0, 6, 1, 1, 1);
      wait_drain("t6b", 30);
      check("t6_wrap1", 96'(stat_nic_pkts), 96'd1);
      compare_logs("t6");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
